// File: rtl/fetch_pc_unit.sv
// ============================================================================
// fetch_pc_unit : fetch stage owning the fetch PC; BTB lookup, imem read,
//                 IQ push with one-entry hold buffer and redirect discard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] btb_pc,
    input  logic [31:0] btb_next_pc,
    input  logic        btb_pred_taken,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        iq_full,
    output logic        iq_push,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_inst,
    output logic        iq_pred_taken,
    output logic [31:0] iq_pred_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_pred_taken;
    logic [31:0] r_req_target;
    logic [31:0] r_hold_inst;

    logic        w_issue;
    logic        w_push;
    logic        w_unused_ok;

    // Fetch addresses are word aligned; low address bits are dropped on load.
    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    always_comb begin
        w_issue = !rst && !redirect_valid && (r_state == S_REQ);
        w_push  = !rst && !redirect_valid && !iq_full &&
                  (((r_state == S_WAIT) && imem_resp) || (r_state == S_HOLD));
    end

    assign btb_pc     = r_pc;
    assign imem_rmask = w_issue ? 4'hF : 4'h0;
    assign iq_push    = w_push;

    always_comb begin
        imem_addr      = 32'd0;
        iq_pc          = 32'd0;
        iq_inst        = 32'd0;
        iq_pred_taken  = 1'b0;
        iq_pred_target = 32'd0;
        if (!rst) begin
            imem_addr      = (r_state == S_REQ) ? r_pc : r_req_pc;
            iq_pc          = r_req_pc;
            iq_pred_taken  = r_req_pred_taken;
            iq_pred_target = r_req_target;
            if (r_state == S_HOLD) begin
                iq_inst = r_hold_inst;
            end else if (r_state == S_WAIT) begin
                iq_inst = imem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_state          <= S_REQ;
            r_req_pc         <= 32'd0;
            r_req_pred_taken <= 1'b0;
            r_req_target     <= 32'd0;
            r_hold_inst      <= 32'd0;
        end else if (redirect_valid) begin
            r_pc        <= {redirect_pc[31:2], 2'b00};
            r_hold_inst <= 32'd0;
            case (r_state)
                S_REQ:     r_state <= S_REQ;
                S_HOLD:    r_state <= S_REQ;
                // A response arriving with the redirect settles the owed read.
                S_WAIT,
                S_DISCARD: r_state <= imem_resp ? S_REQ : S_DISCARD;
                default:   r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    r_req_pc         <= r_pc;
                    r_req_pred_taken <= btb_pred_taken;
                    r_req_target     <= btb_next_pc;
                    r_pc             <= {btb_next_pc[31:2], 2'b00};
                    r_state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_resp) begin
                        if (iq_full) begin
                            r_hold_inst <= imem_rdata;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!iq_full) begin
                        r_state <= S_REQ;
                    end
                end
                S_DISCARD: begin
                    if (imem_resp) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ============================================================================
// tb_fetch_pc_unit : randomized bench with a transaction-level fetch model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    localparam logic [31:0] C_RESET_PC = 32'h1eceb000;
    localparam int          C_DIRECTED = 60;
    localparam int          C_CYCLES   = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] btb_pc, btb_next_pc;
    logic        btb_pred_taken;
    logic [31:0] imem_addr, imem_rdata = 32'd0;
    logic [3:0]  imem_rmask;
    logic        imem_resp = 1'b0;
    logic        iq_full = 1'b0;
    logic        iq_push, iq_pred_taken;
    logic [31:0] iq_pc, iq_inst, iq_pred_target;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        mode = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hashv(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h ^ (h >> 15);
    endfunction

    function automatic logic btaken(input logic [31:0] pc, input logic m);
        logic [31:0] h;
        h = hashv(pc);
        if (!m) return pc == 32'h1eceb008;
        return h[2:0] == 3'd0;
    endfunction

    function automatic logic [31:0] bnext(input logic [31:0] pc, input logic m);
        logic [31:0] h;
        h = hashv(pc);
        if (!btaken(pc, m)) return pc + 32'd4;
        if (!m) return 32'h1eceb100;
        return C_RESET_PC + {18'd0, h[13:2], 2'b00};
    endfunction

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h01000193) ^ 32'hdeadbeef;
    endfunction

    // Small BTB and instruction memory owned by the bench.
    assign btb_next_pc    = bnext(btb_pc, mode);
    assign btb_pred_taken = btaken(btb_pc, mode);

    fetch_pc_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .btb_pc(btb_pc), .btb_next_pc(btb_next_pc), .btb_pred_taken(btb_pred_taken),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .iq_full(iq_full), .iq_push(iq_push), .iq_pc(iq_pc), .iq_inst(iq_inst),
        .iq_pred_taken(iq_pred_taken), .iq_pred_target(iq_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] exp_pc = C_RESET_PC;
        logic        pend = 1'b0, arrived = 1'b0;
        logic [31:0] e_pc = 0, e_inst = 0, e_tgt = 0;
        logic        e_tk = 1'b0;
        logic        mem_busy = 1'b0;
        int          mem_resp_cyc = 0;
        logic [31:0] mem_data = 0;
        int          rst_cyc = 0, reqidx = 0, pushes = 0, lat = 1;
        logic        real_resp, exp_req, exp_push;

        for (int cyc = 0; cyc < C_DIRECTED + C_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < C_DIRECTED) begin
                mode           = 1'b0;
                rst            = (cyc < 2) || (cyc == 35);
                iq_full        = (cyc >= 11 && cyc <= 14) || cyc == 27 || cyc == 28;
                redirect_valid = (cyc == 19) || (cyc == 25) || (cyc == 28);
                redirect_pc    = (cyc == 19) ? 32'h1eceb200 :
                                 (cyc == 25) ? 32'h1eceb302 : 32'h1eceb400;
                lat            = (cyc == 18 || cyc == 19) ? 3 : 1;
            end else begin
                mode           = 1'b1;
                rst            = ($urandom % 300) == 0;
                iq_full        = ($urandom % 10) < 3;
                redirect_valid = ($urandom % 25) == 0;
                redirect_pc    = C_RESET_PC + $urandom_range(0, 4095);
                lat            = $urandom_range(1, 4);
            end
            imem_resp  = !rst && mem_busy && (cyc == mem_resp_cyc);
            imem_rdata = imem_resp ? mem_data : $urandom;
            // A stray pulse while idle must be ignored by the fetch unit.
            if (cyc >= C_DIRECTED && !rst && !mem_busy && !pend && ($urandom % 8) == 0) begin
                imem_resp = 1'b1;
            end
            // Redirect together with the response of an already-discarded read is not exercised.
            if (imem_resp && mem_busy && !pend) redirect_valid = 1'b0;

            @(negedge clk);
            real_resp = imem_resp && mem_busy;
            exp_req   = !rst && !redirect_valid && !pend && !mem_busy;
            exp_push  = !rst && !redirect_valid && pend && (arrived || real_resp) && !iq_full;

            if (rst) begin
                check_eq("rst_rmask", {28'd0, imem_rmask}, 32'd0);
                check_eq("rst_addr", imem_addr, 32'd0);
                check_eq("rst_push", {31'd0, iq_push}, 32'd0);
                check_eq("rst_iq_pc", iq_pc, 32'd0);
                check_eq("rst_iq_inst", iq_inst, 32'd0);
                check_eq("rst_iq_taken", {31'd0, iq_pred_taken}, 32'd0);
                check_eq("rst_iq_target", iq_pred_target, 32'd0);
            end else begin
                check_eq("btb_pc", btb_pc, exp_pc);
                check_eq("rmask", {28'd0, imem_rmask}, exp_req ? 32'hF : 32'h0);
                if (exp_req) check_eq("req_addr", imem_addr, exp_pc);
                check_eq("push", {31'd0, iq_push}, {31'd0, exp_push});
                if (exp_push) begin
                    check_eq("iq_pc", iq_pc, e_pc);
                    check_eq("iq_inst", iq_inst, e_inst);
                    check_eq("iq_taken", {31'd0, iq_pred_taken}, {31'd0, e_tk});
                    check_eq("iq_target", iq_pred_target, e_tgt);
                end
                if (cyc < C_DIRECTED && exp_req && reqidx < 3) begin
                    check_eq("seq_req_cycle", cyc - rst_cyc, 2 * reqidx + 1);
                end
            end

            if (rst) begin
                pend     = 1'b0;
                mem_busy = 1'b0;
                exp_pc   = C_RESET_PC;
                rst_cyc  = cyc;
                reqidx   = 0;
            end else begin
                if (real_resp) begin
                    mem_busy = 1'b0;
                    if (pend) arrived = 1'b1;
                end
                if (redirect_valid) begin
                    pend   = 1'b0;
                    exp_pc = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (exp_push) begin
                        pend = 1'b0;
                        pushes++;
                    end
                    if (exp_req) begin
                        e_pc         = exp_pc;
                        e_inst       = memfn(exp_pc);
                        e_tk         = btaken(exp_pc, mode);
                        e_tgt        = bnext(exp_pc, mode);
                        pend         = 1'b1;
                        arrived      = 1'b0;
                        mem_busy     = 1'b1;
                        mem_resp_cyc = cyc + lat;
                        mem_data     = memfn(imem_addr);
                        exp_pc       = {e_tgt[31:2], 2'b00};
                        reqidx++;
                    end
                end
            end
        end

        check_eq("progress", {31'd0, pushes > 100}, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
